// File: rtl/rpsc_pkg.sv
// Shared types for the RPSC channel power sequencer: state encoding,
// stage-enable vector and the state-to-enable / ramp-down step helpers.
package rpsc_pkg;

    typedef enum logic [3:0] {
        ST_OFF   = 4'd0,
        ST_FAN   = 4'd1,
        ST_DRAMP = 4'd2,
        ST_G1    = 4'd3,
        ST_CA    = 4'd4,
        ST_SB    = 4'd5,
        ST_G2    = 4'd6,
        ST_ANODE = 4'd7,
        ST_HV    = 4'd8
    } rpsc_state_e;

    // bit 0 fan, 1 driver amp, 2 G1, 3 cathode, 4 G2, 5 anode (active-high)
    typedef logic [5:0] rpsc_stage_en_t;

    function automatic rpsc_stage_en_t state_en(input rpsc_state_e st);
        case (st)
            ST_FAN:          state_en = 6'b000001;
            ST_DRAMP:        state_en = 6'b000011;
            ST_G1:           state_en = 6'b000111;
            ST_CA, ST_SB:    state_en = 6'b001111;
            ST_G2:           state_en = 6'b011111;
            ST_ANODE, ST_HV: state_en = 6'b111111;
            default:         state_en = 6'b000000;
        endcase
    endfunction

    function automatic rpsc_state_e ramp_step(input rpsc_state_e st, input rpsc_state_e tgt);
        case (st)
            ST_HV, ST_ANODE: ramp_step = ST_G2;
            ST_G2:           ramp_step = (tgt == ST_SB) ? ST_SB : ST_CA;
            ST_SB, ST_CA:    ramp_step = ST_G1;
            ST_G1:           ramp_step = ST_DRAMP;
            ST_DRAMP:        ramp_step = ST_FAN;
            default:         ramp_step = ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/rpsc_dwell_timer.sv
// Loadable down-counter with synchronous clear; o_tc is high while the count is zero.
module rpsc_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/rpsc_pwr_sequencer.sv
// RPSC channel power-up/down sequencer with trip handling and sticky faults.
// Define RPSC_SEQ_RAMPDN_EN for stepped reverse shutdown on request drops.
module rpsc_pwr_sequencer #(
    parameter int STEP_CYCLES = 1000,
    parameter int HV_TIMEOUT  = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sb_req,
    input  logic       hv_req,
    input  logic       Not_ANY_SB_GO_OFF,
    input  logic       Not_ANY_HV_GO_OFF,
    input  logic       Not_AN_HV_Ready,
    output logic       Not_FAN_ON,
    output logic       Not_DR_AMP_ON,
    output logic       Not_G1_ON,
    output logic       Not_CA_ON,
    output logic       Not_G2_ON,
    output logic       Not_Anode_ON,
    output logic       sb_fault,
    output logic       hv_fault,
    output logic [3:0] state_o
);
    import rpsc_pkg::*;

    // state | meaning: OFF idle; FAN..CA standby ramp-up; SB standby; G2/ANODE HV ramp-up; HV on
    localparam int MAX_CYC = (STEP_CYCLES > HV_TIMEOUT) ? STEP_CYCLES : HV_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HV_LD   = CNT_W'(HV_TIMEOUT - 1);

    rpsc_state_e    r_state, w_next;
    rpsc_stage_en_t r_en;
    logic           r_sb_fault, r_hv_fault;
    logic           w_set_sb, w_set_hv, w_hv_zone, w_tc;
    logic           w_clr, w_load;
    logic [CNT_W-1:0] w_load_val;
`ifdef RPSC_SEQ_RAMPDN_EN
    logic           r_ramp, w_ramp_nxt;
    rpsc_state_e    r_ramp_tgt, w_tgt_nxt;
`endif

    assign w_hv_zone = (r_state == ST_G2) || (r_state == ST_ANODE) || (r_state == ST_HV);

    always_comb begin
        w_next   = r_state;
        w_set_sb = 1'b0;
        w_set_hv = 1'b0;
`ifdef RPSC_SEQ_RAMPDN_EN
        w_ramp_nxt = 1'b0;
        w_tgt_nxt  = r_ramp_tgt;
`endif
        if (r_state == ST_OFF) begin
            if (sb_req && !r_sb_fault && Not_ANY_SB_GO_OFF) w_next = ST_FAN;
        end else if (!Not_ANY_SB_GO_OFF) begin
            w_next   = ST_OFF;
            w_set_sb = 1'b1;
            w_set_hv = w_hv_zone && !Not_ANY_HV_GO_OFF;
        end else if (w_hv_zone && !Not_ANY_HV_GO_OFF) begin
            w_next   = ST_SB;
            w_set_hv = 1'b1;
        end
`ifdef RPSC_SEQ_RAMPDN_EN
        else if (r_ramp) begin
            if (w_tc) w_next = ramp_step(r_state, r_ramp_tgt);
            w_ramp_nxt = (w_next != r_ramp_tgt);
        end else if (!sb_req) begin
            w_tgt_nxt  = ST_OFF;
            w_next     = ramp_step(r_state, ST_OFF);
            w_ramp_nxt = (w_next != ST_OFF);
        end else if (w_hv_zone && !hv_req) begin
            w_tgt_nxt  = ST_SB;
            w_next     = ramp_step(r_state, ST_SB);
            w_ramp_nxt = (w_next != ST_SB);
        end
`else
        else if (!sb_req) begin
            w_next = ST_OFF;
        end else if (w_hv_zone && !hv_req) begin
            w_next = ST_SB;
        end
`endif
        else begin
            case (r_state)
                ST_FAN:   if (w_tc) w_next = ST_DRAMP;
                ST_DRAMP: if (w_tc) w_next = ST_G1;
                ST_G1:    if (w_tc) w_next = ST_CA;
                ST_CA:    if (w_tc) w_next = ST_SB;
                ST_SB:    if (hv_req && !r_hv_fault && Not_ANY_HV_GO_OFF) w_next = ST_G2;
                ST_G2:    if (w_tc) w_next = ST_ANODE;
                ST_ANODE: begin
                    if (!Not_AN_HV_Ready) begin
                        w_next = ST_HV;
                    end else if (w_tc) begin
                        w_next   = ST_SB;
                        w_set_hv = 1'b1;
                    end
                end
                ST_HV: begin
                    if (Not_AN_HV_Ready) begin
                        w_next   = ST_SB;
                        w_set_hv = 1'b1;
                    end
                end
                default: w_next = ST_OFF;
            endcase
        end
    end

    // Untimed states park the counter at zero; timed states reload on entry.
    always_comb begin
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_load_val = STEP_LD;
        if (w_next != r_state) begin
            if (w_next == ST_OFF || w_next == ST_SB || w_next == ST_HV) begin
                w_clr = 1'b1;
            end else begin
                w_load = 1'b1;
                if (w_next == ST_ANODE) w_load_val = HV_LD;
            end
        end
    end

    rpsc_dwell_timer #(.W(CNT_W)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_OFF;
            r_en       <= '0;
            r_sb_fault <= 1'b0;
            r_hv_fault <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_en       <= state_en(w_next);
            r_sb_fault <= w_set_sb | (r_sb_fault & sb_req);
            r_hv_fault <= w_set_hv | (r_hv_fault & hv_req);
        end
    end

`ifdef RPSC_SEQ_RAMPDN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ramp     <= 1'b0;
            r_ramp_tgt <= ST_OFF;
        end else begin
            r_ramp     <= w_ramp_nxt;
            r_ramp_tgt <= w_tgt_nxt;
        end
    end
`endif

    assign Not_FAN_ON    = ~r_en[0];
    assign Not_DR_AMP_ON = ~r_en[1];
    assign Not_G1_ON     = ~r_en[2];
    assign Not_CA_ON     = ~r_en[3];
    assign Not_G2_ON     = ~r_en[4];
    assign Not_Anode_ON  = ~r_en[5];
    assign sb_fault      = r_sb_fault;
    assign hv_fault      = r_hv_fault;
    assign state_o       = r_state;

endmodule

// File: tb/tb_rpsc_pwr_sequencer.sv
// Directed self-checking bench for rpsc_pwr_sequencer with STEP_CYCLES=4, HV_TIMEOUT=8.
module tb_rpsc_pwr_sequencer;

    localparam logic [3:0] S_OFF = 4'd0, S_FAN = 4'd1, S_DRAMP = 4'd2, S_G1 = 4'd3,
                           S_CA = 4'd4, S_SB = 4'd5, S_G2 = 4'd6, S_ANODE = 4'd7, S_HV = 4'd8;
    // {Anode, G2, CA, G1, DR_AMP, FAN}, active-low
    localparam logic [5:0] E_OFF = 6'b111111, E_FAN = 6'b111110, E_DRAMP = 6'b111100,
                           E_G1 = 6'b111000, E_SB = 6'b110000, E_G2 = 6'b100000, E_HV = 6'b000000;

    logic clk = 1'b0;
    logic reset, sb_req, hv_req, nsb, nhv, nrdy;
    logic n_fan, n_dr, n_g1, n_ca, n_g2, n_an, sbf, hvf;
    logic [3:0] st;
    logic [5:0] en_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpsc_pwr_sequencer #(.STEP_CYCLES(4), .HV_TIMEOUT(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .sb_req            (sb_req),
        .hv_req            (hv_req),
        .Not_ANY_SB_GO_OFF (nsb),
        .Not_ANY_HV_GO_OFF (nhv),
        .Not_AN_HV_Ready   (nrdy),
        .Not_FAN_ON        (n_fan),
        .Not_DR_AMP_ON     (n_dr),
        .Not_G1_ON         (n_g1),
        .Not_CA_ON         (n_ca),
        .Not_G2_ON         (n_g2),
        .Not_Anode_ON      (n_an),
        .sb_fault          (sbf),
        .hv_fault          (hvf),
        .state_o           (st)
    );

    assign en_n = {n_an, n_g2, n_ca, n_g1, n_dr, n_fan};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] es, input logic [5:0] ee,
                             input logic esb, input logic ehv);
        chk({tag, ".state"}, {2'b00, st}, {2'b00, es});
        chk({tag, ".en_n"}, en_n, ee);
        chk({tag, ".sb_fault"}, {5'b0, sbf}, {5'b0, esb});
        chk({tag, ".hv_fault"}, {5'b0, hvf}, {5'b0, ehv});
    endtask

    // Called right after FAN entry; walks the standby ramp with 4-cycle dwells.
    task automatic walk_to_sb(input string tag);
        logic [3:0] ss [5];
        logic [5:0] se [5];
        ss = '{S_FAN, S_DRAMP, S_G1, S_CA, S_SB};
        se = '{E_FAN, E_DRAMP, E_G1, E_SB, E_SB};
        for (int i = 0; i < 4; i++) begin
            tick(3);
            expect_st($sformatf("%s.hold%0d", tag, i), ss[i], se[i], 1'b0, 1'b0);
            tick(1);
            expect_st($sformatf("%s.step%0d", tag, i), ss[i+1], se[i+1], 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; sb_req = 1'b1; hv_req = 1'b0; nsb = 1'b1; nhv = 1'b1; nrdy = 1'b1;
        tick(3);
        expect_st("reset", S_OFF, E_OFF, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);
        expect_st("fan_entry", S_FAN, E_FAN, 1'b0, 1'b0);
        walk_to_sb("up1");

        hv_req = 1'b1;
        tick(1); expect_st("g2_entry", S_G2, E_G2, 1'b0, 1'b0);
        tick(3); expect_st("g2_hold", S_G2, E_G2, 1'b0, 1'b0);
        tick(1); expect_st("anode_entry", S_ANODE, E_HV, 1'b0, 1'b0);
        tick(2); expect_st("anode_wait", S_ANODE, E_HV, 1'b0, 1'b0);
        nrdy = 1'b0;
        tick(1); expect_st("hv_entry", S_HV, E_HV, 1'b0, 1'b0);

        nsb = 1'b0;
        tick(1); expect_st("sb_trip", S_OFF, E_OFF, 1'b1, 1'b0);
        nsb = 1'b1;
        tick(2); expect_st("sb_blocked", S_OFF, E_OFF, 1'b1, 1'b0);
        sb_req = 1'b0; hv_req = 1'b0; nrdy = 1'b1;
        tick(1); expect_st("sb_clear", S_OFF, E_OFF, 1'b0, 1'b0);
        sb_req = 1'b1;
        tick(1); expect_st("restart", S_FAN, E_FAN, 1'b0, 1'b0);
        walk_to_sb("up2");

        hv_req = 1'b1;
        tick(1); expect_st("to_g2", S_G2, E_G2, 1'b0, 1'b0);
        tick(4); expect_st("to_anode", S_ANODE, E_HV, 1'b0, 1'b0);
        tick(7); expect_st("anode_last", S_ANODE, E_HV, 1'b0, 1'b0);
        tick(1); expect_st("hv_timeout", S_SB, E_SB, 1'b0, 1'b1);
        tick(2); expect_st("hv_sticky", S_SB, E_SB, 1'b0, 1'b1);
        hv_req = 1'b0;
        tick(1); expect_st("hv_clear", S_SB, E_SB, 1'b0, 1'b0);

        hv_req = 1'b1;
        tick(1); expect_st("g2_again", S_G2, E_G2, 1'b0, 1'b0);
        hv_req = 1'b0;
        tick(1); expect_st("hv_drop", S_SB, E_SB, 1'b0, 1'b0);

        hv_req = 1'b1;
        tick(5); expect_st("anode2", S_ANODE, E_HV, 1'b0, 1'b0);
        nrdy = 1'b0;
        tick(1); expect_st("hv2", S_HV, E_HV, 1'b0, 1'b0);
        nrdy = 1'b1;
        tick(1); expect_st("ready_loss", S_SB, E_SB, 1'b0, 1'b1);
        hv_req = 1'b0;
        tick(1); expect_st("ready_clear", S_SB, E_SB, 1'b0, 1'b0);

        hv_req = 1'b1;
        tick(5); expect_st("anode3", S_ANODE, E_HV, 1'b0, 1'b0);
        nrdy = 1'b0;
        tick(1); expect_st("hv3", S_HV, E_HV, 1'b0, 1'b0);
        nsb = 1'b0; nhv = 1'b0;
        tick(1); expect_st("dual_trip", S_OFF, E_OFF, 1'b1, 1'b1);
        nsb = 1'b1; nhv = 1'b1; sb_req = 1'b0; hv_req = 1'b0; nrdy = 1'b1;
        tick(1); expect_st("dual_clear", S_OFF, E_OFF, 1'b0, 1'b0);

        sb_req = 1'b1;
        tick(1); expect_st("restart2", S_FAN, E_FAN, 1'b0, 1'b0);
        walk_to_sb("up3");
        hv_req = 1'b1;
        tick(5); expect_st("anode4", S_ANODE, E_HV, 1'b0, 1'b0);
        nrdy = 1'b0;
        tick(1); expect_st("hv4", S_HV, E_HV, 1'b0, 1'b0);
        sb_req = 1'b0;
`ifdef RPSC_SEQ_RAMPDN_EN
        begin
            logic [3:0] rs [6];
            logic [5:0] re [6];
            rs = '{S_G2, S_CA, S_G1, S_DRAMP, S_FAN, S_OFF};
            re = '{E_G2, E_SB, E_G1, E_DRAMP, E_FAN, E_OFF};
            tick(1); expect_st("rd_first", rs[0], re[0], 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) begin
                tick(3);
                expect_st($sformatf("rd_hold%0d", i), rs[i], re[i], 1'b0, 1'b0);
                tick(1);
                expect_st($sformatf("rd_step%0d", i), rs[i+1], re[i+1], 1'b0, 1'b0);
            end
        end
`else
        tick(1); expect_st("sb_drop", S_OFF, E_OFF, 1'b0, 1'b0);
`endif
        tick(2); expect_st("final_off", S_OFF, E_OFF, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
